// File: rtl/adc16dv160_input_common.sv
// adc16dv160_input_common: register map, response codes and read FSM states shared by the input IP
package adc16dv160_input_common;
  localparam logic [7:0] AXI_ADDR_CR    = 8'h00;
  localparam logic [7:0] AXI_ADDR_DSIZE = 8'h04;
  localparam logic [7:0] AXI_ADDR_SR    = 8'h08;
  localparam logic [7:0] AXI_ADDR_CNT   = 8'h0C;
  localparam logic [7:0] AXI_ADDR_VER   = 8'h10;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {S0, S1, S2} rd_state_t;
endpackage

// File: rtl/adc16dv160_sticky_flag.sv
// adc16dv160_sticky_flag: event flag that holds until cleared; a set in the clear cycle wins
module adc16dv160_sticky_flag (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic set,
  input  logic clr,
  output logic flag
);
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) flag <= 1'b0;
    else          flag <= set | (flag & ~clr);
endmodule

// File: rtl/adc16dv160_input_read.sv
// adc16dv160_input_read: AXI4-Lite read responder for the input block registers
module adc16dv160_input_read
  import adc16dv160_input_common::*;
#(
  parameter int          DECODE_W = 8,
  parameter logic [31:0] VERSION  = 32'h0001_0000
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic [31:0] dsize,
  input  logic        cr_test,
  input  logic        cr_rt,
  input  logic        busy,
  input  logic        done_pulse,
  input  logic        ovf_pulse,
  input  logic [31:0] sample_cnt
);
  rd_state_t             state, state_nxt;
  logic [DECODE_W-1:0]   addr;
  logic [31:0]           rd_data;
  logic [1:0]            rd_resp;
  logic                  done_sticky, ovf_sticky, sr_clr;
  logic                  unused_addr;
  assign addr        = ARADDR[DECODE_W-1:0];
  assign unused_addr = ^ARADDR[31:DECODE_W];
  assign ARREADY     = state == S1;
  assign RVALID      = state == S2;
  // Flags are cleared on the same edge that snapshots them into RDATA
  assign sr_clr      = ARREADY && addr == DECODE_W'(AXI_ADDR_SR);
  always_comb begin
    state_nxt = state;
    state_nxt = state == S0 ? (ARVALID ? S1 : S0) :
                state == S1 ? S2 : (RREADY ? S0 : S2);
  end
  always_comb begin
    rd_data = '0;
    rd_resp = AXI_RESP_OKAY;
    case (addr)
      DECODE_W'(AXI_ADDR_CR):    rd_data = {29'b0, cr_rt, cr_test, 1'b0};
      DECODE_W'(AXI_ADDR_DSIZE): rd_data = dsize;
      DECODE_W'(AXI_ADDR_SR):    rd_data = {29'b0, ovf_sticky, done_sticky, busy};
      DECODE_W'(AXI_ADDR_CNT):   rd_data = sample_cnt;
      DECODE_W'(AXI_ADDR_VER):   rd_data = VERSION;
      default:                   rd_resp = AXI_RESP_SLVERR;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state <= S0;
      RDATA <= '0;
      RRESP <= AXI_RESP_OKAY;
    end else begin
      state <= state_nxt;
      if (ARREADY) begin
        RDATA <= rd_data;
        RRESP <= rd_resp;
      end
    end
  adc16dv160_sticky_flag u_done (
    .ACLK(ACLK), .ARESETN(ARESETN), .set(done_pulse), .clr(sr_clr), .flag(done_sticky)
  );
  adc16dv160_sticky_flag u_ovf (
    .ACLK(ACLK), .ARESETN(ARESETN), .set(ovf_pulse), .clr(sr_clr), .flag(ovf_sticky)
  );
endmodule

// File: tb/tb_adc16dv160_input_read.sv
// tb_adc16dv160_input_read: scoreboard bench with a register-map reference model and random traffic
module tb_adc16dv160_input_read;
  logic        ACLK = 0, ARESETN = 0;
  logic [31:0] ARADDR = 0;
  logic        ARVALID = 0, ARREADY, RVALID, RREADY = 1;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic [31:0] dsize = 0, sample_cnt = 0;
  logic        cr_test = 0, cr_rt = 0, busy = 0, done_pulse = 0, ovf_pulse = 0;
  int          tests = 0, fails = 0;
  bit          rand_en = 0;
  bit          m_done = 0, m_ovf = 0;
  logic [33:0] exp_q[$];
  logic [33:0] last_exp = 0;

  adc16dv160_input_read dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY), .dsize(dsize),
    .cr_test(cr_test), .cr_rt(cr_rt), .busy(busy), .done_pulse(done_pulse),
    .ovf_pulse(ovf_pulse), .sample_cnt(sample_cnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {RRESP, RDATA} for an address given the bench's current view of inputs and flags
  function automatic logic [33:0] ref_read(input logic [31:0] a);
    case (a % 256)
      0:       return {2'b00, 32'((cr_rt ? 4 : 0) + (cr_test ? 2 : 0))};
      4:       return {2'b00, dsize};
      8:       return {2'b00, 32'((m_ovf ? 4 : 0) + (m_done ? 2 : 0) + (busy ? 1 : 0))};
      12:      return {2'b00, sample_cnt};
      16:      return {2'b00, 32'h0001_0000};
      default: return {2'b10, 32'h0};
    endcase
  endfunction

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      exp_q.delete();
      m_done = 0;
      m_ovf = 0;
    end else begin
      if (ARREADY) begin
        last_exp = ref_read(ARADDR);
        exp_q.push_back(last_exp);
        if (ARADDR % 256 == 8) begin
          m_done = 0;
          m_ovf = 0;
        end
      end
      if (done_pulse) m_done = 1;
      if (ovf_pulse) m_ovf = 1;
    end
  end

  always @(negedge ACLK) begin
    if (ARESETN && RVALID && RREADY) begin
      if (exp_q.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
      else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("rdata", RDATA, e[31:0]);
        chk("rresp", 32'(RRESP), 32'(e[33:32]));
      end
    end
  end

  initial forever begin
    @(posedge ACLK); #1;
    if (rand_en) begin
      done_pulse = $urandom_range(0, 5) == 0;
      ovf_pulse  = $urandom_range(0, 5) == 0;
      busy       = 1'($urandom);
      cr_test    = 1'($urandom);
      cr_rt      = 1'($urandom);
      RREADY     = $urandom_range(0, 2) != 0;
      sample_cnt = sample_cnt + 1;
      if ($urandom_range(0, 3) == 0) dsize = $urandom;
    end
  end

  task automatic do_read(input logic [31:0] a, input bit ovf_s1, input bit hold,
                         input bit dchk, input logic [31:0] xd, input logic [1:0] xr);
    bit hs;
    @(posedge ACLK); #1;
    ARADDR = a;
    ARVALID = 1;
    @(negedge ACLK);
    chk("s0_arready", 32'(ARREADY), 32'd0);
    @(posedge ACLK); #1;
    if (ovf_s1) ovf_pulse = 1;
    @(negedge ACLK);
    chk("s1_arready", 32'(ARREADY), 32'd1);
    chk("s1_rvalid", 32'(RVALID), 32'd0);
    @(posedge ACLK); #1;
    ARVALID = 0;
    if (ovf_s1) ovf_pulse = 0;
    @(negedge ACLK);
    chk("s2_arready", 32'(ARREADY), 32'd0);
    chk("s2_rvalid", 32'(RVALID), 32'd1);
    if (dchk) begin
      chk("directed_rdata", RDATA, xd);
      chk("directed_rresp", 32'(RRESP), 32'(xr));
    end
    if (hold) return;
    hs = 0;
    for (int i = 0; i < 40 && !hs; i++) begin
      if (RVALID && RREADY) hs = 1;
      else @(negedge ACLK);
    end
    if (!hs) chk("handshake_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_done();
    @(posedge ACLK); #1;
    done_pulse = 1;
    @(posedge ACLK); #1;
    done_pulse = 0;
  endtask

  initial begin
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_rresp", 32'(RRESP), 32'd0);
    #2 ARESETN = 1;
    dsize = 32'h0000_1000;
    do_read(32'h04, 0, 0, 1, 32'h0000_1000, 2'b00);
    cr_test = 1;
    cr_rt = 1;
    do_read(32'h00, 0, 0, 1, 32'h0000_0006, 2'b00);
    do_read(32'h10, 0, 0, 1, 32'h0001_0000, 2'b00);
    pulse_done();
    do_read(32'h08, 0, 0, 1, 32'h2, 2'b00);
    do_read(32'h08, 0, 0, 1, 32'h0, 2'b00);
    do_read(32'h08, 1, 0, 1, 32'h0, 2'b00);
    do_read(32'h08, 0, 0, 1, 32'h4, 2'b00);
    do_read(32'h3C, 0, 0, 1, 32'h0, 2'b10);
    do_read(32'h104, 0, 0, 1, 32'h0000_1000, 2'b00);
    sample_cnt = 32'h100;
    do_read(32'h0C, 0, 0, 1, 32'h100, 2'b00);
    rand_en = 1;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 6);
      a = k < 5 ? 32'(k * 4) : k == 5 ? 32'($urandom_range(5, 63) * 4) :
          (($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 4) * 4));
      if ($urandom_range(0, 3) == 0) a = a | 32'h1;
      do_read(a, 0, 0, 0, 32'h0, 2'b00);
    end
    rand_en = 0;
    @(posedge ACLK); #1;
    done_pulse = 0;
    ovf_pulse = 0;
    busy = 0;
    RREADY = 1;
    do_read(32'h08, 0, 0, 0, 32'h0, 2'b00);
    pulse_done();
    RREADY = 0;
    do_read(32'h0C, 0, 1, 0, 32'h0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      @(posedge ACLK); #1;
      sample_cnt = sample_cnt + 3;
      ovf_pulse = i == 4;
      @(negedge ACLK);
      chk("hold_rvalid", 32'(RVALID), 32'd1);
      chk("hold_arready", 32'(ARREADY), 32'd0);
      chk("hold_rdata", RDATA, last_exp[31:0]);
    end
    #2 ARESETN = 0;
    #1;
    chk("async_rvalid", 32'(RVALID), 32'd0);
    chk("async_rdata", RDATA, 32'd0);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    #2 ARESETN = 1;
    RREADY = 1;
    do_read(32'h08, 0, 0, 1, 32'h0, 2'b00);
    repeat (3) @(negedge ACLK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
